// File: rtl/aurora_tx_pkg.sv
// Shared types and constants for the Aurora AXIS transmit arbiter.
package aurora_tx_pkg;

    // Arbiter FSM: waiting for a request, streaming a packet, inter-packet gap.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_GAPW = 2'd2
    } state_t;

    // Default packet length limit before the grant is forcibly released.
    localparam int MAXBEATS_DEF = 512;

    // Mux select value meaning "no source granted".
    localparam logic [2:0] SEL_IDLE = 3'b100;

endpackage

// File: rtl/aurora_axi_tx_arb_if.sv
// Bundle of AXIS request/handshake signals between the sources, the arbiter
// and the downstream tx mux.
interface aurora_axi_tx_arb_if #(
    parameter int ETHCOUNT = 4
);
    logic [ETHCOUNT-1:0] s_tvalid;
    logic [ETHCOUNT-1:0] s_tlast;
    logic                m_tready;
    logic [2:0]          axis_s_sel;
    logic [ETHCOUNT-1:0] grant;
    logic                busy;
    logic [ETHCOUNT-1:0] overrun;
    logic                overrun_clr;

    // Arbiter side: sees requests, drives the select and status.
    modport slave (
        input  s_tvalid, s_tlast, m_tready, overrun_clr,
        output axis_s_sel, grant, busy, overrun
    );

    // Source/host side: drives requests, observes the select and status.
    modport master (
        output s_tvalid, s_tlast, m_tready, overrun_clr,
        input  axis_s_sel, grant, busy, overrun
    );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requesting index strictly after
// 'last', scanning upward with wrap-around.
module rr_pick #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   last,
    output logic [1:0]   idx,
    output logic         hit
);

    // Scan candidates last+1 .. last+N; the first hit wins, so ties cannot occur.
    always_comb begin
        idx = '0;
        hit = 1'b0;
        for (int k = 1; k <= N; k++) begin
            if (!hit && req[(int'(last) + k) % N]) begin
                hit = 1'b1;
                idx = 2'((int'(last) + k) % N);
            end
        end
    end

endmodule

// File: rtl/aurora_axi_tx_arb.sv
// Packet-level round-robin arbiter selecting one of ETHCOUNT AXIS sources
// for the shared Aurora tx mux. A grant is held from the first beat until
// tlast (or a forced release at MAXBEATS), followed by GAP idle cycles.
module aurora_axi_tx_arb
    import aurora_tx_pkg::*;
#(
    parameter int ETHCOUNT = 4,
    parameter int MAXBEATS = MAXBEATS_DEF,
    parameter int GAP      = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    aurora_axi_tx_arb_if.slave   bus
);

    localparam int CW = $clog2(MAXBEATS + 1);

    state_t              state, state_n;
    logic [ETHCOUNT-1:0] grant_q, grant_n;
    logic [ETHCOUNT-1:0] ovr_q, ovr_set;
    logic [2:0]          sel_q, sel_n;
    logic                busy_q, busy_n;
    logic [CW-1:0]       cnt_q, cnt_n;
    logic [1:0]          gap_q, gap_n;
    logic [1:0]          last_q, last_n;
    logic [1:0]          pick_idx;
    logic                pick_hit;
    logic                beat;
    logic                at_max;

    rr_pick #(.N(ETHCOUNT)) u_pick (
        .req  (bus.s_tvalid),
        .last (last_q),
        .idx  (pick_idx),
        .hit  (pick_hit)
    );

    // last_q always holds the index of the current (or most recent) grant.
    assign beat   = bus.s_tvalid[last_q] & bus.m_tready;
    assign at_max = (cnt_q + 1'b1) == CW'(MAXBEATS);

    // Next-state and next-output decode; outputs only change on state entry.
    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_n = state;
        grant_n = grant_q;
        sel_n   = sel_q;
        busy_n  = busy_q;
        cnt_n   = cnt_q;
        gap_n   = gap_q;
        last_n  = last_q;
        ovr_set = '0;
        case (state)
            ST_IDLE: begin
                if (pick_hit) begin
                    state_n = ST_PKT;
                    grant_n = ETHCOUNT'(1) << pick_idx;
                    sel_n   = {1'b0, pick_idx};
                    busy_n  = 1'b1;
                    last_n  = pick_idx;
                    cnt_n   = '0;
                end
            end
            ST_PKT: begin
                if (beat) begin
                    if (bus.s_tlast[last_q] || at_max) begin
                        // tlast on the limit beat is a normal end, not an overrun.
                        if (!bus.s_tlast[last_q]) ovr_set[last_q] = 1'b1;
                        grant_n = '0;
                        sel_n   = SEL_IDLE;
                        busy_n  = 1'b0;
                        cnt_n   = '0;
                        gap_n   = '0;
                        state_n = (GAP == 0) ? ST_IDLE : ST_GAPW;
                    end else begin
                        cnt_n = cnt_q + 1'b1;
                    end
                end
            end
            ST_GAPW: begin
                if (gap_q == 2'(GAP - 1)) state_n = ST_IDLE;
                else                      gap_n   = gap_q + 1'b1;
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset aborts any packet without flagging overrun.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            sel_q   <= SEL_IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            gap_q   <= '0;
            last_q  <= 2'(ETHCOUNT - 1);
            ovr_q   <= '0;
        end else begin
            state   <= state_n;
            grant_q <= grant_n;
            sel_q   <= sel_n;
            busy_q  <= busy_n;
            cnt_q   <= cnt_n;
            gap_q   <= gap_n;
            last_q  <= last_n;
            // A new overrun beats a simultaneous clear.
            ovr_q   <= (ovr_q & {ETHCOUNT{~bus.overrun_clr}}) | ovr_set;
        end
    end

    assign bus.grant      = grant_q;
    assign bus.axis_s_sel = sel_q;
    assign bus.busy       = busy_q;
    assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_aurora_axi_tx_arb.sv
// Directed self-checking bench for aurora_axi_tx_arb (ETHCOUNT=4, MAXBEATS=8,
// GAP=1). Timing model: a request seen in IDLE is granted on the next edge;
// the grant drops on the edge after the releasing beat; GAPW lasts GAP
// cycles, then one IDLE arbitration cycle precedes the next grant.
module tb_aurora_axi_tx_arb;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    aurora_axi_tx_arb_if #(.ETHCOUNT(4)) bus ();

    aurora_axi_tx_arb #(
        .ETHCOUNT (4),
        .MAXBEATS (8),
        .GAP      (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.s_tvalid    = '0;
        bus.s_tlast     = '0;
        bus.m_tready    = 1'b0;
        bus.overrun_clr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.s_tvalid    = '0;
        bus.s_tlast     = '0;
        bus.m_tready    = 1'b0;
        bus.overrun_clr = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        checks++; if (bus.axis_s_sel !== 3'b100) begin failures++; $display("FAIL reset_sel got=%b exp=100", bus.axis_s_sel); end
        checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL reset_grant got=%b exp=0000", bus.grant); end
        rst = 1'b0;
        repeat (2) tick();
        checks++; if (bus.axis_s_sel !== 3'b100) begin failures++; $display("FAIL idle_sel got=%b exp=100", bus.axis_s_sel); end
        checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL idle_grant got=%b exp=0000", bus.grant); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL idle_overrun got=%b exp=0000", bus.overrun); end
    endtask

    // All four sources request 2-beat packets back to back: period of 4 cycles.
    task automatic test_round_robin();
        int bcnt[4];
        logic [3:0] eg;
        logic [2:0] es;
        for (int i = 0; i < 4; i++) bcnt[i] = 0;
        apply_reset();
        bus.s_tvalid = 4'hF;
        bus.m_tready = 1'b1;
        for (int c = 0; c <= 20; c++) begin
            for (int i = 0; i < 4; i++) bus.s_tlast[i] = (bcnt[i] == 1);
            if (c >= 1 && ((c - 1) % 4) < 2) begin
                eg = 4'b0001 << (((c - 1) / 4) % 4);
                es = {1'b0, 2'(((c - 1) / 4) % 4)};
            end else begin
                eg = 4'b0000;
                es = 3'b100;
            end
            checks++; if (bus.grant !== eg) begin failures++; $display("FAIL rr_grant c=%0d got=%b exp=%b", c, bus.grant, eg); end
            checks++; if (bus.axis_s_sel !== es) begin failures++; $display("FAIL rr_sel c=%0d got=%b exp=%b", c, bus.axis_s_sel, es); end
            checks++; if (bus.busy !== (eg != 0)) begin failures++; $display("FAIL rr_busy c=%0d got=%b exp=%b", c, bus.busy, (eg != 0)); end
            tick();
            for (int i = 0; i < 4; i++) if (eg[i]) bcnt[i] = (bcnt[i] + 1) % 2;
        end
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
    endtask

    // Source 2, 4 beats, tready 0,1,0,1...: grant held 8 cycles.
    task automatic test_backpressure();
        int nb;
        logic [3:0] eg;
        nb = 0;
        apply_reset();
        bus.s_tvalid = 4'b0100;
        for (int c = 0; c <= 9; c++) begin
            bus.m_tready = (c >= 2) && (c % 2 == 0);
            bus.s_tlast  = (nb == 3) ? 4'b0100 : 4'b0000;
            eg = (c >= 1 && c <= 8) ? 4'b0100 : 4'b0000;
            checks++; if (bus.grant !== eg) begin failures++; $display("FAIL bp_grant c=%0d got=%b exp=%b", c, bus.grant, eg); end
            if (c == 4) begin
                checks++; if (bus.axis_s_sel !== 3'b010) begin failures++; $display("FAIL bp_sel got=%b exp=010", bus.axis_s_sel); end
            end
            tick();
            if (eg != 0 && bus.m_tready) nb++;
        end
        checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL bp_overrun got=%b exp=0000", bus.overrun); end
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;
    endtask

    // tvalid dropping mid-packet must not release the grant.
    task automatic test_valid_drop();
        logic [3:0] eg;
        apply_reset();
        bus.m_tready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            bus.s_tvalid = (c == 2 || c == 3) ? 4'b0000 : 4'b0001;
            bus.s_tlast  = (c == 4) ? 4'b0001 : 4'b0000;
            if (c == 5) bus.s_tvalid = 4'b0000;
            eg = (c >= 1 && c <= 4) ? 4'b0001 : 4'b0000;
            checks++; if (bus.grant !== eg) begin failures++; $display("FAIL drop_grant c=%0d got=%b exp=%b", c, bus.grant, eg); end
            tick();
        end
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;
    endtask

    // Source 1 streams without tlast: forced release after beat 8.
    task automatic test_overrun();
        logic [3:0] eg, eo;
        apply_reset();
        bus.s_tvalid = 4'b0010;
        bus.m_tready = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            eg = (c >= 1 && c <= 8) ? 4'b0010 : 4'b0000;
            eo = (c >= 9) ? 4'b0010 : 4'b0000;
            checks++; if (bus.grant !== eg) begin failures++; $display("FAIL ovr_grant c=%0d got=%b exp=%b", c, bus.grant, eg); end
            checks++; if (bus.overrun !== eo) begin failures++; $display("FAIL ovr_flag c=%0d got=%b exp=%b", c, bus.overrun, eo); end
            if (c == 9) bus.s_tvalid = 4'b0000;
            tick();
        end
        checks++; if (bus.overrun !== 4'b0010) begin failures++; $display("FAIL ovr_sticky got=%b exp=0010", bus.overrun); end
        bus.overrun_clr = 1'b1;
        tick();
        bus.overrun_clr = 1'b0;
        checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL ovr_clear got=%b exp=0000", bus.overrun); end
        // Clear held high across a second overrun: the set must win.
        bus.overrun_clr = 1'b1;
        bus.s_tvalid    = 4'b0010;
        repeat (9) tick();
        bus.s_tvalid = 4'b0000;
        checks++; if (bus.overrun !== 4'b0010) begin failures++; $display("FAIL ovr_set_wins got=%b exp=0010", bus.overrun); end
        tick();
        checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL ovr_clr_after got=%b exp=0000", bus.overrun); end
        bus.overrun_clr = 1'b0;
        bus.m_tready    = 1'b0;
    endtask

    // Reset during beat 3 of source 0 aborts at once; arbitration restarts at 0.
    task automatic test_mid_reset();
        apply_reset();
        bus.s_tvalid = 4'b0001;
        bus.m_tready = 1'b1;
        repeat (3) tick();
        checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL mr_pre_grant got=%b exp=0001", bus.grant); end
        rst = 1'b1;
        #1;
        checks++; if (bus.grant !== 4'b0000) begin failures++; $display("FAIL mr_grant got=%b exp=0000", bus.grant); end
        checks++; if (bus.axis_s_sel !== 3'b100) begin failures++; $display("FAIL mr_sel got=%b exp=100", bus.axis_s_sel); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL mr_busy got=%b exp=0", bus.busy); end
        bus.s_tvalid = 4'hF;
        tick();
        rst = 1'b0;
        checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL mr_overrun got=%b exp=0000", bus.overrun); end
        tick();
        checks++; if (bus.grant !== 4'b0001) begin failures++; $display("FAIL mr_regrant got=%b exp=0001", bus.grant); end
        checks++; if (bus.axis_s_sel !== 3'b000) begin failures++; $display("FAIL mr_resel got=%b exp=000", bus.axis_s_sel); end
        bus.s_tvalid = '0;
        bus.m_tready = 1'b0;
    endtask

    // Source 3 alone with 1-beat packets: grant 1 cycle, GAPW 1, IDLE 1.
    task automatic test_single_beat();
        logic [3:0] eg;
        apply_reset();
        bus.s_tvalid = 4'b1000;
        bus.s_tlast  = 4'b1000;
        bus.m_tready = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            eg = (c >= 1 && (c - 1) % 3 == 0) ? 4'b1000 : 4'b0000;
            checks++; if (bus.grant !== eg) begin failures++; $display("FAIL sb_grant c=%0d got=%b exp=%b", c, bus.grant, eg); end
            checks++; if (bus.axis_s_sel !== ((eg != 0) ? 3'b011 : 3'b100)) begin failures++; $display("FAIL sb_sel c=%0d got=%b", c, bus.axis_s_sel); end
            tick();
        end
        checks++; if (bus.overrun !== 4'b0000) begin failures++; $display("FAIL sb_overrun got=%b exp=0000", bus.overrun); end
        bus.s_tvalid = '0;
        bus.s_tlast  = '0;
        bus.m_tready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_valid_drop();
        test_overrun();
        test_mid_reset();
        test_single_beat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
